// File: rtl/issue_pkg.sv
// Shared constants, FU codes and the control-field record kept per issue-queue entry.
package issue_pkg;
  localparam int DEPTH     = 4;
  localparam int PAYLOAD_W = 76;
  localparam int NFU       = 5;
  localparam int REG_W     = 6;
  localparam int NREG      = 1 << REG_W;
  localparam int FU_W      = 3;

  localparam logic [FU_W-1:0]  FU_ALU   = 3'd0;
  localparam logic [FU_W-1:0]  FU_BRU   = 3'd2;
  localparam logic [FU_W-1:0]  FU_LSU   = 3'd3;
  localparam logic [FU_W-1:0]  FU_HILO  = 3'd4;
  localparam logic [REG_W-1:0] REG_HILO = 6'd32;

  typedef struct packed {
    logic [FU_W-1:0]  fu;
    logic [REG_W-1:0] reg1;
    logic [REG_W-1:0] reg2;
    logic [REG_W-1:0] reg3;
    logic             r1_val;
    logic             r2_val;
    logic             rf_we;
  } iq_ctrl_t;

  function automatic logic src_clear(input logic used, input logic busy);
    return ~used | ~busy;
  endfunction
endpackage

// File: rtl/sb_busy_table.sv
// Register busy scoreboard: one set port, one clear port, three combinational read ports.
module sb_busy_table
  import issue_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_set_en,
  input  logic [REG_W-1:0] i_set_idx,
  input  logic             i_clr_en,
  input  logic [REG_W-1:0] i_clr_idx,
  input  logic [REG_W-1:0] i_rd1_idx,
  input  logic [REG_W-1:0] i_rd2_idx,
  input  logic [REG_W-1:0] i_rd3_idx,
  output logic             o_rd1_busy,
  output logic             o_rd2_busy,
  output logic             o_rd3_busy
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;

  // r0 is hardwired zero, so it is never tracked; a set of the same bit
  // being cleared wins because it belongs to the younger producer.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en && (i_set_idx != '0)) w_set_mask[i_set_idx] = 1'b1;
    if (i_clr_en) w_clr_mask[i_clr_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~NREG'(1);
  end

  assign o_rd1_busy = r_busy[i_rd1_idx];
  assign o_rd2_busy = r_busy[i_rd2_idx];
  assign o_rd3_busy = r_busy[i_rd3_idx];
endmodule

// File: rtl/issue_sched.sv
// In-order issue queue: FIFO of decoded ops, head issues when operands, destination and FU are free.
module issue_sched #(
  parameter int DEPTH     = issue_pkg::DEPTH,
  parameter int PAYLOAD_W = issue_pkg::PAYLOAD_W,
  parameter int NFU       = issue_pkg::NFU
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fu,
  input  logic [5:0]           in_reg1,
  input  logic [5:0]           in_reg2,
  input  logic                 in_r1_val,
  input  logic                 in_r2_val,
  input  logic [5:0]           in_reg3,
  input  logic                 in_rf_we,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [NFU-1:0]       fu_busy,
  output logic                 iss_valid,
  output logic [2:0]           iss_fu,
  output logic [5:0]           iss_reg3,
  output logic                 iss_rf_we,
  output logic [PAYLOAD_W-1:0] iss_payload,
  input  logic                 wb_valid,
  input  logic [5:0]           wb_reg,
  output logic [15:0]          stall_cnt
);
  import issue_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  iq_ctrl_t             r_ctrl [DEPTH];
  logic [PAYLOAD_W-1:0] r_pay  [DEPTH];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic [15:0]          r_stall;

  iq_ctrl_t             w_in_ctrl;
  iq_ctrl_t             w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_issue;
  logic                 w_ready;
  logic                 w_b1;
  logic                 w_b2;
  logic                 w_b3;
  logic [(1<<FU_W)-1:0] w_fu_busy_ext;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = ~w_full;
  assign w_push   = in_valid & ~w_full & ~flush;

  assign w_in_ctrl = '{fu: in_fu, reg1: in_reg1, reg2: in_reg2, reg3: in_reg3,
                       r1_val: in_r1_val, r2_val: in_r2_val, rf_we: in_rf_we};
  assign w_head    = r_ctrl[r_rptr];

  // Codes with no physical unit read as permanently busy so they can never issue.
  always_comb begin
    w_fu_busy_ext          = '1;
    w_fu_busy_ext[NFU-1:0] = fu_busy;
  end

  sb_busy_table u_busy (
    .clk        (clk),
    .reset      (reset),
    .i_set_en   (w_issue & w_head.rf_we),
    .i_set_idx  (w_head.reg3),
    .i_clr_en   (wb_valid),
    .i_clr_idx  (wb_reg),
    .i_rd1_idx  (w_head.reg1),
    .i_rd2_idx  (w_head.reg2),
    .i_rd3_idx  (w_head.reg3),
    .o_rd1_busy (w_b1),
    .o_rd2_busy (w_b2),
    .o_rd3_busy (w_b3)
  );

  assign w_ready = src_clear(w_head.r1_val, w_b1) & src_clear(w_head.r2_val, w_b2) &
                   src_clear(w_head.rf_we, w_b3);
  assign w_issue = ~w_empty & w_ready & ~w_fu_busy_ext[w_head.fu] & ~flush;

  assign iss_valid   = w_issue;
  assign iss_fu      = w_issue ? w_head.fu    : '0;
  assign iss_reg3    = w_issue ? w_head.reg3  : '0;
  assign iss_rf_we   = w_issue ? w_head.rf_we : 1'b0;
  assign iss_payload = w_issue ? r_pay[r_rptr] : '0;
  assign stall_cnt   = r_stall;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ctrl[r_wptr] <= w_in_ctrl;
      r_pay[r_wptr]  <= in_payload;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_wptr <= r_wptr + PTR_W'(1);
      if (w_issue) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_stall <= '0;
    else if (~w_empty & ~w_issue & ~flush) r_stall <= sat_inc16(r_stall);
  end
endmodule

// File: tb/tb_issue_sched.sv
// Randomized plus directed bench for issue_sched against a queue-based behavioural model.
module tb_issue_sched;
  localparam int DEPTH = 4;
  localparam int PW    = 76;
  localparam int NFU   = 5;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic [2:0]    in_fu;
  logic [5:0]    in_reg1, in_reg2, in_reg3;
  logic          in_r1_val, in_r2_val, in_rf_we;
  logic [PW-1:0] in_payload;
  logic [NFU-1:0] fu_busy;
  logic          iss_valid, iss_rf_we;
  logic [2:0]    iss_fu;
  logic [5:0]    iss_reg3;
  logic [PW-1:0] iss_payload;
  logic          wb_valid;
  logic [5:0]    wb_reg;
  logic [15:0]   stall_cnt;

  issue_sched #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .NFU(NFU)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_fu(in_fu),
    .in_reg1(in_reg1), .in_reg2(in_reg2), .in_r1_val(in_r1_val), .in_r2_val(in_r2_val),
    .in_reg3(in_reg3), .in_rf_we(in_rf_we), .in_payload(in_payload), .fu_busy(fu_busy),
    .iss_valid(iss_valid), .iss_fu(iss_fu), .iss_reg3(iss_reg3), .iss_rf_we(iss_rf_we),
    .iss_payload(iss_payload), .wb_valid(wb_valid), .wb_reg(wb_reg), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    fu;
    logic [5:0]    r1, r2, r3;
    logic          v1, v2, we;
    logic [PW-1:0] pay;
  } ent_t;

  ent_t mq[$];
  logic mbusy [64];
  int   mstall;
  int   checks   = 0;
  int   failures = 0;
  int   n_issued = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic head_ready(input ent_t h);
    return (!h.v1 || !mbusy[h.r1]) && (!h.v2 || !mbusy[h.r2]) && (!h.we || !mbusy[h.r3]);
  endfunction

  // Monitor / scoreboard: samples at negedge, inputs are stable and no edge is pending.
  always @(negedge clk) begin
    logic exp_ready, exp_iss, fb;
    int   f;
    ent_t h, n;
    if (reset) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_iss_valid", iss_valid, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      mstall = 0;
    end else begin
      exp_ready = (mq.size() < DEPTH);
      exp_iss   = 1'b0;
      if (mq.size() > 0 && !flush) begin
        h  = mq[0];
        f  = int'(h.fu);
        fb = 1'b1;
        if (f < NFU) fb = fu_busy[f];
        exp_iss = head_ready(h) && !fb;
      end
      chk("in_ready", in_ready, exp_ready);
      chk("iss_valid", iss_valid, exp_iss);
      chk("stall_cnt", stall_cnt, mstall);
      if (iss_valid && mq.size() > 0) begin
        chk("iss_fu", iss_fu, mq[0].fu);
        chk("iss_reg3", iss_reg3, mq[0].r3);
        chk("iss_rf_we", iss_rf_we, mq[0].we);
        chk("iss_payload", iss_payload, mq[0].pay);
      end else if (iss_valid) begin
        chk("iss_on_empty_queue", 1, 0);
      end else begin
        chk("iss_fields_idle", {iss_fu, iss_reg3, iss_rf_we, iss_payload}, 0);
      end
      if (wb_valid) mbusy[wb_reg] = 1'b0;
      if (exp_iss && h.we && h.r3 != 0) mbusy[h.r3] = 1'b1;
      if (mq.size() > 0 && !exp_iss && !flush && mstall < 65535) mstall++;
      if (exp_iss) n_issued++;
      if (flush) mq.delete();
      else begin
        if (exp_iss) void'(mq.pop_front());
        if (in_valid && exp_ready) begin
          n.fu = in_fu; n.r1 = in_reg1; n.r2 = in_reg2; n.r3 = in_reg3;
          n.v1 = in_r1_val; n.v2 = in_r2_val; n.we = in_rf_we; n.pay = in_payload;
          mq.push_back(n);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; wb_valid = 0; wb_reg = 0;
  endtask

  task automatic offer(input logic [2:0] fu, input logic [5:0] r1, input logic v1,
                       input logic [5:0] r2, input logic v2, input logic [5:0] r3,
                       input logic we);
    logic [95:0] p;
    p = {$urandom, $urandom, $urandom};
    in_valid = 1; in_fu = fu; in_reg1 = r1; in_r1_val = v1; in_reg2 = r2;
    in_r2_val = v2; in_reg3 = r3; in_rf_we = we; in_payload = p[PW-1:0];
  endtask

  task automatic wb(input logic [5:0] r);
    wb_valid = 1; wb_reg = r;
  endtask

  initial begin
    reset = 1; fu_busy = '0;
    idle();
    offer(3'd0, 6'd0, 0, 6'd0, 0, 6'd0, 0);
    in_valid = 0;
    tick(); tick();
    reset = 0;
    tick();

    // addiu r2 then addu r3,r2,r2: dependent op waits for writeback of r2
    offer(3'd0, 6'd1, 1, 6'd0, 0, 6'd2, 1); tick();
    offer(3'd0, 6'd2, 1, 6'd2, 1, 6'd3, 1); tick();
    idle(); tick(); tick(); tick();
    wb(6'd2); tick();
    idle(); tick(); tick();
    wb(6'd3); tick(); idle(); tick();

    // Four blocked LSU ops fill the queue, a fifth is refused, then drain and wrap
    fu_busy = 5'b01000;
    for (int i = 0; i < 5; i++) begin offer(3'd3, 6'd0, 0, 6'd0, 0, 6'd0, 0); tick(); end
    idle(); tick();
    fu_busy = '0; tick(); tick(); tick(); tick(); tick();
    for (int i = 0; i < 6; i++) begin offer(3'd2, 6'd0, 0, 6'd0, 0, 6'd0, 0); tick(); end
    idle(); tick(); tick();

    // Flush with three queued entries; busy bit from an issued op survives
    offer(3'd0, 6'd0, 0, 6'd0, 0, 6'd6, 1); tick();
    fu_busy = 5'b01000;
    for (int i = 0; i < 3; i++) begin offer(3'd3, 6'd0, 0, 6'd0, 0, 6'd0, 0); tick(); end
    offer(3'd3, 6'd0, 0, 6'd0, 0, 6'd0, 0); flush = 1; tick();
    idle(); fu_busy = '0; tick();
    offer(3'd0, 6'd6, 1, 6'd0, 0, 6'd7, 0); tick();
    idle(); tick(); tick();
    wb(6'd6); tick(); idle(); tick();

    // Writes to r0 never mark it busy
    offer(3'd0, 6'd0, 0, 6'd0, 0, 6'd0, 1); tick();
    offer(3'd0, 6'd0, 1, 6'd0, 1, 6'd0, 1); tick();
    idle(); tick(); tick();

    // Reset mid-operation with two queued entries and r5 busy
    offer(3'd0, 6'd0, 0, 6'd0, 0, 6'd5, 1); tick();
    fu_busy = 5'b01000;
    offer(3'd3, 6'd0, 0, 6'd0, 0, 6'd0, 0); tick();
    offer(3'd3, 6'd0, 0, 6'd0, 0, 6'd0, 0); tick();
    idle();
    reset = 1; #1;
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_iss_valid", iss_valid, 0);
    chk("async_rst_stall", stall_cnt, 0);
    tick(); tick();
    reset = 0; fu_busy = '0;
    wb(6'd5); tick(); idle();
    offer(3'd0, 6'd5, 1, 6'd5, 1, 6'd5, 1); tick();
    idle(); tick(); tick();
    wb(6'd5); tick(); idle(); tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] ra, rb, rc;
      ra = ($urandom_range(0, 9) == 0) ? 6'd32 : 6'($urandom_range(0, 7));
      rb = 6'($urandom_range(0, 7));
      rc = ($urandom_range(0, 9) == 0) ? 6'd32 : 6'($urandom_range(0, 7));
      offer(($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
            ra, 1'($urandom), rb, 1'($urandom), rc, 1'($urandom));
      in_valid = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      fu_busy  = NFU'($urandom) & NFU'($urandom);
      wb_valid = 1'($urandom);
      wb_reg   = ($urandom_range(0, 9) == 0) ? 6'd32 : 6'($urandom_range(0, 7));
      reset    = (c == 1500);
      tick();
    end
    reset = 0; idle(); fu_busy = '0;
    for (int i = 0; i < 8; i++) begin wb(6'(i)); tick(); end
    wb(6'd32); tick(); idle(); tick(); tick();

    checks++;
    if (n_issued < 100) begin
      failures++;
      $display("FAIL issue_activity: got %0d issues expected at least 100", n_issued);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 Parameter DEPTH, default 4: issue-queue entries, power of two.
REQ-002 Parameter PAYLOAD_W, default 76: opaque payload width (op 12 + imm 32 + pc 32).
REQ-003 Parameter NFU, default 5: functional-unit count; fu codes 0..NFU-1.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  branch/exception flush; discards queued, unissued entries.
REQ-007 in_valid  in  1  decoded instruction offered.
REQ-008 in_ready  out  1  queue can accept this cycle.
REQ-009 in_fu  in  3  target functional unit code.
REQ-010 in_reg1, in_reg2  in  6 each  source register indices (32 = hi/lo).
REQ-011 in_r1_val, in_r2_val  in  1 each  source actually read.
REQ-012 in_reg3  in  6  destination index; in_rf_we  in  1  destination written.
REQ-013 in_payload  in  PAYLOAD_W  carried unchanged to issue.
REQ-014 fu_busy  in  NFU  bit n set: unit n cannot accept this cycle.
REQ-015 iss_valid  out  1  issue pulse; iss_fu 3, iss_reg3 6, iss_rf_we 1, iss_payload PAYLOAD_W  out  head-entry fields.
REQ-016 wb_valid  in  1, wb_reg  in  6  writeback completes, clears busy for wb_reg.
REQ-017 stall_cnt  out  16  cycles head was valid but not issued.

Function
REQ-018 Queue SHALL be an in-order FIFO; push when in_valid & in_ready & ~flush.
REQ-019 in_ready SHALL equal ~full; no same-cycle pop credit.
REQ-020 Pointers SHALL wrap modulo DEPTH; count range 0..DEPTH.
REQ-021 Entry pushed at cycle t SHALL be eligible at head no earlier than t+1.
REQ-022 Busy table: 64 bits; bit 0 SHALL never be set.
REQ-023 Head ready = (~r1_val | ~busy[reg1]) & (~r2_val | ~busy[reg2]) & (~rf_we | ~busy[reg3]) (WAW stall).
REQ-024 iss_valid SHALL be combinational = ~empty & head ready & ~fu_busy[head fu] & ~flush; pop same cycle.
REQ-025 Readiness SHALL use registered busy only; no same-cycle writeback bypass.
REQ-026 On issue with rf_we and reg3 != 0, busy[reg3] SHALL set next edge.
REQ-027 On wb_valid, busy[wb_reg] SHALL clear next edge; clearing a non-busy bit is a no-op.
REQ-028 Issue-set and wb-clear of different bits same cycle SHALL both take effect.
REQ-029 flush SHALL empty queue next edge (pointers, count to 0), drop same-cycle push, suppress iss_valid; busy table unaffected.
REQ-030 Push to full queue SHALL not occur (in_ready low); push and pop same cycle on non-full queue SHALL keep count.
REQ-031 fu code >= NFU SHALL be treated as always busy (never issues).
REQ-032 stall_cnt SHALL increment when ~empty & ~iss_valid & ~flush, saturating at 16'hFFFF.
REQ-033 iss_* data outputs SHALL be zero when iss_valid is low.

Reset
REQ-034 reset SHALL asynchronously clear pointers, count, busy table, stall_cnt; in_ready=1, iss_valid=0 during and after reset.
REQ-035 reset mid-operation SHALL discard all entries; in-flight writebacks after reset SHALL be no-ops.

Structure
REQ-036 Package issue_pkg SHALL hold DEPTH, PAYLOAD_W, NFU, register-index width, FU codes (ALU 0, BRU 2, LSU 3, HILO 4), HILO index 32.
REQ-037 Busy table SHALL be sub-module sb_busy_table (set port, clear port, two-read-plus-one ports); FIFO stays inline.

Verification
REQ-038 Push addiu r2 (fu 0, rf_we, reg3=2) into empty queue -> iss_valid at t+1, busy[2] set at t+2.
REQ-039 addiu r2 then addu r3,r2,r2 -> second stalls, stall_cnt increments; wb_reg=2 at t -> second issues t+1.
REQ-040 Fill 4 entries with fu_busy[3]=1 LSU ops -> in_ready=0, 5th push refused; release -> one issue/cycle, pointers wrap correctly.
REQ-041 flush with 3 entries queued and in_valid high -> count 0 next cycle, no iss_valid, busy bits from issued ops retained.
REQ-042 Write to reg3=0 with rf_we -> issues, busy[0] stays 0; subsequent reader of r0 issues without stall.
REQ-043 Assert reset with 2 entries and busy[5] set -> in_ready=1, iss_valid=0, busy cleared immediately.
